// File: rtl/serial_addsub_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor.
// Holds the FSM state encoding and the bit-counter width rule.
// No logic of its own; imported by serial_addsub.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // A counter over N bit positions needs clog2(N) bits, but never fewer than one.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full adder cell, shared with the parallel ripple adder.
// Latency: purely combinational.
// Backpressure: none, no handshake.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Sum is odd parity; carry is the majority of the three inputs.
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial N-bit adder/subtractor, bit-exact with the parallel ripple unit.
// Latency: out_valid rises N clocks after the accepting edge; one op per N+2 clocks.
// Backpressure: operands taken only in IDLE; result held in DONE until out_ready.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  input  logic         carry_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         carry_out,
  output logic         overflow
);

  localparam int            CW   = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [N-1:0]    r_a_sr;
  logic [N-1:0]    r_b_sr;
  logic [N-1:0]    r_res;
  logic [N-1:0]    w_res_shift;
  logic            r_carry;
  logic            r_cmsb;
  logic            w_sum;
  logic            w_cout;
  logic            w_last;

  assign w_last = (r_cnt == LAST);

  // Single full adder works on the current LSB of both operand shift registers.
  full_adder_bit u_fa (
    .a    (r_a_sr[0]),
    .b    (r_b_sr[0]),
    .cin  (r_carry),
    .s    (w_sum),
    .cout (w_cout)
  );

  // Result fills from the top so that after N shifts bit 0 sits at the LSB.
  always_comb begin
    w_res_shift        = r_res >> 1;
    w_res_shift[N-1]   = w_sum;
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state: accept in IDLE, shift N bits, hold in DONE until drained.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_next = SHIFT;
      SHIFT:   if (w_last)    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default:                w_next = IDLE;
    endcase
  end

  // Outputs: results are only exposed in DONE, zero otherwise.
  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    result    = (r_state == DONE) ? r_res : '0;
    carry_out = (r_state == DONE) & r_carry;
    overflow  = (r_state == DONE) & (r_cmsb ^ r_carry);
  end

  // Datapath: load operands (B pre-inverted for subtract), then one bit per clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cmsb  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a_sr  <= a;
            r_b_sr  <= b ^ {N{sub}};
            r_carry <= carry_in ^ sub;
            r_cnt   <= '0;
            r_res   <= '0;
            r_cmsb  <= 1'b0;
          end
        end
        SHIFT: begin
          r_res   <= w_res_shift;
          r_carry <= w_cout;
          r_a_sr  <= r_a_sr >> 1;
          r_b_sr  <= r_b_sr >> 1;
          if (w_last) begin
            // Carry entering the MSB, needed for signed overflow.
            r_cmsb <= r_carry;
          end else begin
            r_cnt  <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed and exhaustive checks of serial_addsub at N=4.
// Drives and samples 1 time unit after the rising edge.
// Expected values are hand-computed or from an independent golden equation.
module tb_serial_addsub;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         sub;
  logic         carry_in;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic         carry_out;
  logic         overflow;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_addsub #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Golden {overflow, carry_out, result} from the arithmetic definition.
  function automatic logic [5:0] golden(input logic [3:0] ga, input logic [3:0] gb,
                                        input logic gs, input logic gc);
    logic [3:0] bp;
    logic       c0;
    logic [4:0] full;
    logic [3:0] low;
    bp   = gb ^ {4{gs}};
    c0   = gc ^ gs;
    full = {1'b0, ga} + {1'b0, bp} + {4'b0, c0};
    low  = {1'b0, ga[2:0]} + {1'b0, bp[2:0]} + {3'b0, c0};
    return {low[3] ^ full[4], full[4], full[3:0]};
  endfunction

  // Present operands in IDLE and return just after the accepting edge.
  task automatic start(input logic [N-1:0] ta, input logic [N-1:0] tb,
                       input logic ts, input logic tc);
    a        = ta;
    b        = tb;
    sub      = ts;
    carry_in = tc;
    in_valid = 1'b1;
    check("in_ready_before_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid; latency must be exactly N edges.
  task automatic wait_done(input string tag);
    int lat;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (!out_valid && lat == 1) begin
        check({tag, "_busy_in_ready"}, in_ready, 0);
        check({tag, "_busy_result"}, {carry_out, overflow, result}, 0);
      end
    end while (!out_valid && lat < 20);
    check({tag, "_latency"}, lat, N);
  endtask

  // Hold off the consumer for dly cycles, then handshake once.
  task automatic drain(input string tag, input int dly);
    out_ready = 1'b0;
    repeat (dly) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_drained"}, {out_valid, in_ready}, 2'b01);
  endtask

  task automatic run_dir(input string tag, input logic [N-1:0] ta, input logic [N-1:0] tb,
                         input logic ts, input logic tc, input logic [5:0] exp);
    start(ta, tb, ts, tc);
    wait_done(tag);
    check(tag, {overflow, carry_out, result}, exp);
    drain(tag, 1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    carry_in  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_handshake", {in_ready, out_valid}, 2'b10);
    check("reset_outputs", {overflow, carry_out, result}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors: expected {overflow, carry_out, result}
    run_dir("add_5_3",      4'd5,  4'd3, 1'b0, 1'b0, 6'b10_1000);
    run_dir("sub_3_5",      4'd3,  4'd5, 1'b1, 1'b0, 6'b00_1110);
    run_dir("add_15_1_ci",  4'd15, 4'd1, 1'b0, 1'b1, 6'b01_0001);
    run_dir("sub_5_3_bi",   4'd5,  4'd3, 1'b1, 1'b1, 6'b01_0001);

    // Backpressure: stall DONE with new operands waiting on in_valid.
    start(4'd5, 4'd3, 1'b0, 1'b0);
    wait_done("bp");
    a        = 4'd1;
    b        = 4'd1;
    sub      = 1'b0;
    carry_in = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp_hold_outputs", {out_valid, in_ready, overflow, carry_out, result}, 8'b10_10_1000);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_back_to_idle", {out_valid, in_ready}, 2'b01);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_new_accepted", in_ready, 0);
    wait_done("bp_new");
    check("bp_new_result", {overflow, carry_out, result}, 6'b00_0010);
    drain("bp_new", 0);

    // Reset in the middle of SHIFT discards the operation.
    start(4'd7, 4'd7, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_handshake", {in_ready, out_valid}, 2'b10);
    check("midrst_result", {overflow, carry_out, result}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_dir("after_rst_2_2", 4'd2, 4'd2, 1'b0, 1'b0, 6'b00_0100);

    // Exhaustive sweep with random consumer delay.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int is = 0; is < 2; is++) begin
          for (int ic = 0; ic < 2; ic++) begin
            start(4'(ia), 4'(ib), 1'(is), 1'(ic));
            wait_done("sweep");
            check("sweep_result", {overflow, carry_out, result},
                  golden(4'(ia), 4'(ib), 1'(is), 1'(ic)));
            drain("sweep", int'($urandom_range(0, 3)));
          end
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Bit-serial counterpart of the team's parallel N-bit ripple-carry adder/subtractor.
- Accepts a, b, sub and carry_in in parallel through a valid/ready handshake.
- Computes one bit per clock using a single full adder and a carry flip-flop.
- Presents the N-bit result, carry_out and signed overflow through an output valid/ready handshake.
- Intended for area-constrained datapaths. Must be bit-exact with the parallel unit for every input combination.

Parameters:
- N, 4, operand/result width in bits (N >= 1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- a  input  N  operand A.
- b  input  N  operand B.
- sub  input  1  0 = add, 1 = subtract.
- carry_in  input  1  carry-in when adding; borrow-in when subtracting.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- result  output  N  sum/difference.
- carry_out  output  1  carry out of MSB; 0 means a borrow occurred when subtracting.
- overflow  output  1  two's-complement overflow.

Behaviour:
- Arithmetic:
  - B' = b XOR {N{sub}}; c0 = carry_in XOR sub.
  - {carry_out, result} = a + B' + c0, taken modulo 2^(N+1).
  - overflow = (carry into MSB) XOR carry_out.
- Reset: state IDLE; counter 0; internal registers 0; in_ready = 1; out_valid = 0; result, carry_out and overflow = 0. Reset takes effect immediately, including mid-operation; any partial result is discarded.
- FSM states:
  - IDLE: in_ready = 1. On clk edge with in_valid = 1:
    - latch a into a shift register and B' into a shift register;
    - carry register <= c0; counter <= 0; go to SHIFT.
  - SHIFT: in_ready = 0. Each edge:
    - sum bit = a_sr[0] ^ b_sr[0] ^ carry; shift the sum bit into the MSB of the result register (LSB-first fill);
    - carry <= majority(a_sr[0], b_sr[0], carry); shift both operand registers right;
    - counter increments.
    - On the edge processing bit N-1: capture the carry into bit N-1 for overflow, then go to DONE.
  - DONE: out_valid = 1; result, carry_out and overflow held stable. On edge with out_ready = 1, go to IDLE (out_valid drops).
- Latency: out_valid rises exactly N clocks after the accepting edge. Throughput is one operation per N+2 clocks at best (accept, N shifts, drain).
- in_valid is ignored in SHIFT and DONE. No overlap: a new operand is accepted only in IDLE, at the earliest one cycle after the out_ready handshake.
- out_ready outside DONE has no effect.
- Operand inputs are sampled only on the accepting edge; later changes do not affect the operation in progress.
- N = 1: SHIFT lasts one cycle. Overflow = c0 XOR carry_out (the carry into the MSB is c0).
- The counter is $clog2(N) bits, minimum 1 bit. The counter never wraps; the terminal count is N-1.
- result, carry_out and overflow are 0 in IDLE and SHIFT, and are driven from registers only in DONE.

Decomposition:
- Package serial_addsub_pkg holds:
  - the state enum (IDLE, SHIFT, DONE);
  - a function for the counter width.
- One natural sub-module: full_adder_bit (a, b, cin -> s, cout, combinational), instantiated once. The same cell is reusable by the parallel unit.

Test Plan:
1. N=4, a=5, b=3, sub=0, carry_in=0 -> result=1000, carry_out=0, overflow=1; out_valid rises 4 clocks after accept.
2. a=3, b=5, sub=1, carry_in=0 -> result=1110 (-2), carry_out=0 (borrow), overflow=0.
3. a=15, b=1, sub=0, carry_in=1 -> result=0001, carry_out=1, overflow=0.
4. a=5, b=3, sub=1, carry_in=1 -> result=0001, carry_out=1, overflow=0.
5. Backpressure: hold out_ready=0 for 3 cycles in DONE while in_valid=1 with new operands -> outputs stay stable, in_ready=0, new operands are not taken. Then pulse out_ready -> IDLE next cycle, then the new operands are accepted.
6. Assert rst two cycles into SHIFT -> out_valid=0, result=0, in_ready=1 immediately. The next operation (a=2, b=2, add) then gives result=0100.
7. Exhaustive run: all 16x16x2x2 combinations, with random out_ready delays, compared against the golden equation above.
